// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words LSB-first onto a configuration chain head and
// repacks the bits leaving the chain tail into readback words.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              chain_shift_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);
  localparam int NW        = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CHAIN_LEN - (NW - 1) * WORD_W;
  localparam int LW        = $clog2(WORD_W + 1);
  localparam int BW        = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [CNT_W-1:0] NW_C      = CNT_W'(NW);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [LW-1:0]    FULL_BITS = LW'(WORD_W);
  localparam logic [LW-1:0]    TAIL_BITS = LW'(LAST_BITS);
  localparam logic [BW-1:0]    RB_TOP    = BW'(WORD_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [WORD_W-1:0] wreg;
  logic              full;
  logic [LW-1:0]     bits_left;
  logic [CNT_W-1:0]  words_acc;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] rb_sr;
  logic [BW-1:0]     rb_cnt;

  logic              shift, last_in_wreg, accept, chain_end;
  logic [WORD_W-1:0] rb_word;

  assign shift        = (state == S_LOAD) && full;
  assign last_in_wreg = shift && (bits_left == LW'(1));
  // A new word may land on the same edge that shifts out the last valid bit.
  assign in_ready     = (state == S_LOAD) && (words_acc < NW_C) && (!full || last_in_wreg);
  assign accept       = in_ready && in_valid;
  assign chain_end    = shift && (bit_cnt == LAST_IDX);

  assign chain_shift_en = shift;
  assign ccff_head      = shift & wreg[0];
  assign busy           = (state == S_LOAD);
  assign done           = (state == S_DONE);

  assign rb_word = rb_sr | (WORD_W'(ccff_tail) << rb_cnt);

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state     <= S_IDLE;
      wreg      <= '0;
      full      <= 1'b0;
      bits_left <= '0;
      words_acc <= '0;
      bit_cnt   <= '0;
      rb_sr     <= '0;
      rb_cnt    <= '0;
      rb_data   <= '0;
      rb_valid  <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_LOAD;
            wreg      <= '0;
            full      <= 1'b0;
            bits_left <= '0;
            words_acc <= '0;
            bit_cnt   <= '0;
            rb_sr     <= '0;
            rb_cnt    <= '0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            wreg      <= in_data;
            full      <= 1'b1;
            bits_left <= (words_acc == NW_C - CNT_W'(1)) ? TAIL_BITS : FULL_BITS;
            words_acc <= words_acc + CNT_W'(1);
          end else if (shift) begin
            wreg      <= wreg >> 1;
            bits_left <= bits_left - LW'(1);
            if (last_in_wreg) full <= 1'b0;
          end
          if (shift) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            // Readback word closes on a full word or on the final chain bit;
            // a short final word keeps its upper bits at zero.
            if (rb_cnt == RB_TOP || chain_end) begin
              rb_data  <= rb_word;
              rb_valid <= 1'b1;
              rb_sr    <= '0;
              rb_cnt   <= '0;
            end else begin
              rb_sr  <= rb_word;
              rb_cnt <= rb_cnt + BW'(1);
            end
            if (chain_end) state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomised bench: a behavioural chain shifter feeds ccff_tail, and the
// expected head stream / readback words come from plain word arithmetic.
module tb_ccff_chain_loader;
  localparam int CHAIN_LEN = 20;
  localparam int WORD_W    = 8;
  localparam int NW        = 3;

  logic              prog_clk, pReset, start, in_valid, in_ready;
  logic [WORD_W-1:0] in_data, rb_data;
  logic              ccff_head, chain_shift_en, ccff_tail, rb_valid, busy, done;

  logic [CHAIN_LEN-1:0] chain;
  logic [WORD_W-1:0]    words [NW];
  logic [WORD_W-1:0]    rb_got [NW];
  int                   total, bad, ones;

  logic              s_ready, s_shift, s_head, s_rbv, s_busy, s_done;
  logic [WORD_W-1:0] s_rbd;

  assign ccff_tail = chain[CHAIN_LEN-1];

  ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W), .CNT_W(16)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .ccff_head(ccff_head),
    .chain_shift_en(chain_shift_en), .ccff_tail(ccff_tail), .rb_data(rb_data),
    .rb_valid(rb_valid), .busy(busy), .done(done)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One programming-clock cycle: drive at negedge, sample, let the chain shift.
  task automatic cyc(input logic st, input logic rs, input logic v, input logic [WORD_W-1:0] d);
    start = st; pReset = rs; in_valid = v; in_data = d;
    #1;
    s_ready = in_ready; s_shift = chain_shift_en; s_head = ccff_head;
    s_rbv = rb_valid; s_rbd = rb_data; s_busy = busy; s_done = done;
    @(posedge prog_clk);
    #1;
    if (s_shift) chain = {chain[CHAIN_LEN-2:0], s_head};
    @(negedge prog_clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, s_ready, 0);
    chk({tag, "_shift"}, s_shift, 0);
    chk({tag, "_head"},  s_head, 0);
    chk({tag, "_rbv"},   s_rbv, 0);
    chk({tag, "_rbd"},   s_rbd, 0);
    chk({tag, "_busy"},  s_busy, 0);
    chk({tag, "_done"},  s_done, 0);
  endtask

  task automatic run_load(input bit directed, input int gap_len, input bit rand_gaps,
                          input bit spam, input int reset_at);
    logic [CHAIN_LEN-1:0] exp_chain, old_chain;
    logic [WORD_W-1:0]    rb_exp [NW];
    bit                   exp_bits [CHAIN_LEN];
    int  wi, shifts, rbi, first_rdy, first_sh, last_sh, done_c, gap_left;
    bit  v, st, rs, stalled, gap_stall, prev_gap, aborted;
    old_chain = chain;
    for (int j = 0; j < NW; j++) rb_exp[j] = '0;
    for (int k = 0; k < CHAIN_LEN; k++) begin
      exp_bits[k] = words[k / WORD_W][k % WORD_W];
      exp_chain[CHAIN_LEN-1-k] = exp_bits[k];
      rb_exp[k / WORD_W][k % WORD_W] = old_chain[CHAIN_LEN-1-k];
    end
    wi = 0; shifts = 0; rbi = 0; first_rdy = -1; first_sh = -1; last_sh = -1;
    done_c = -1; gap_left = gap_len; prev_gap = 0; aborted = 0; ones = 0;
    cyc(1, 0, 0, '0);
    for (int c = 1; c <= 200 && done_c < 0 && !aborted; c++) begin
      stalled = 0; gap_stall = 0;
      if (wi == 1 && gap_left > 0 && in_ready) begin
        stalled = 1; gap_stall = 1; gap_left--;
      end else if (rand_gaps && $urandom_range(0, 3) == 0) stalled = 1;
      v  = (wi < NW) && !stalled;
      st = spam ? ($urandom_range(0, 2) == 0) : 1'b0;
      rs = (reset_at >= 0) && (shifts == reset_at);
      cyc(st, rs, v, (wi < NW) ? words[wi] : '0);
      if (c == 1) begin
        chk("start_busy", s_busy, 1);
        chk("start_done_clr", s_done, 0);
      end
      if (gap_stall && prev_gap) chk("stall_noshift", s_shift, 0);
      prev_gap = gap_stall;
      if (wi >= NW) chk("ready_after_last", s_ready, 0);
      if (s_ready && first_rdy < 0) first_rdy = c;
      if (s_ready && v) wi++;
      if (s_shift) begin
        if (shifts < CHAIN_LEN) chk("head_bit", s_head, exp_bits[shifts]);
        if (first_sh < 0) first_sh = c;
        last_sh = c;
        ones += int'(s_head);
        shifts++;
      end
      if (s_rbv) begin
        if (rbi < NW) begin
          chk("rb_word", s_rbd, rb_exp[rbi]);
          rb_got[rbi] = s_rbd;
        end
        rbi++;
      end
      if (s_done) done_c = c;
      if (rs) aborted = 1;
    end
    if (aborted) begin
      cyc(0, 0, 0, '0);
      chk_all_zero("after_reset");
    end else begin
      chk("load_finished", done_c >= 0, 1);
      chk("shift_total", shifts, CHAIN_LEN);
      chk("words_taken", wi, NW);
      chk("rb_pulses", rbi, NW);
      chk("chain_cfg", chain, exp_chain);
      chk("done_not_busy", s_busy, 0);
      if (directed) begin
        chk("first_ready_cyc", first_rdy, 1);
        chk("first_shift_cyc", first_sh, 2);
        chk("last_shift_cyc", last_sh, 21);
        chk("done_cyc", done_c, 22);
      end
      cyc(0, 0, 0, '0);
      chk("done_sticky", s_done, 1);
      chk("rb_single_pulse", s_rbv, 0);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    prog_clk = 0; pReset = 0; start = 0; in_valid = 0; in_data = '0;
    chain = '0;
    @(negedge prog_clk);
    cyc(0, 1, 0, '0);
    cyc(1, 1, 1, 8'hFF);
    cyc(0, 0, 0, '0);
    chk_all_zero("reset");

    // Round trip: preloaded all-ones chain reads back with a padded final word.
    chain = '1;
    words[0] = 8'h00; words[1] = 8'h00; words[2] = 8'h00;
    run_load(1, 0, 0, 0, -1);
    chk("rt_word0", rb_got[0], 8'hFF);
    chk("rt_word1", rb_got[1], 8'hFF);
    chk("rt_word2", rb_got[2], 8'h0F);

    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'h0F;
    run_load(1, 0, 0, 0, -1);
    run_load(0, 5, 0, 0, -1);

    words[0] = 8'h00; words[1] = 8'h00; words[2] = 8'hFF;
    run_load(0, 0, 0, 0, -1);
    chk("discard_ones", ones, 4);

    for (int n = 0; n < 6; n++) begin
      for (int j = 0; j < NW; j++) words[j] = WORD_W'($urandom);
      run_load(0, 0, 1, n[0], -1);
    end

    for (int j = 0; j < NW; j++) words[j] = WORD_W'($urandom);
    run_load(0, 0, 0, 0, 10);
    run_load(0, 0, 1, 0, -1);

    cyc(1, 1, 0, '0);
    cyc(0, 0, 0, '0);
    chk("start_vs_reset_busy", s_busy, 0);
    chk("start_vs_reset_ready", s_ready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Drives the configuration chain of a logical tile or a chain of tiles, at the chain's ccff_head input end.
- Accepts bitstream words over a valid/ready handshake, serialises them LSB-first onto ccff_head, and emits a per-bit shift enable.
- Captures the bits leaving ccff_tail and repacks them as readback words, so the previous chain contents can be checked.
- Sits in the programming-clock domain between the bitstream source and the first tile's ccff_head.

Parameters:
- CHAIN_LEN, 20: total configuration bits in the attached chain; must be ≥1.
- WORD_W, 8: bitstream and readback word width; must be ≥1.
- CNT_W, 16: width of the internal bit counter; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- prog_clk  input  1  programming clock; all state updates on its rising edge.
- pReset  input  1  synchronous active-high reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
- in_data  input  WORD_W  bitstream word; bit 0 is shifted first.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts in_data this cycle.
- ccff_head  output  1  serial config bit to the chain head.
- chain_shift_en  output  1  chain shifts on a prog_clk edge only when this is high.
- ccff_tail  input  1  serial bit returned from the chain tail.
- rb_data  output  WORD_W  readback word, first tail bit in bit 0.
- rb_valid  output  1  one-cycle pulse; rb_data valid.
- busy  output  1  high in LOAD.
- done  output  1  sticky high in DONE.

Behaviour:
- Reset: all outputs are 0 one edge after pReset is sampled high.
  - This covers in_ready, ccff_head, chain_shift_en, rb_data, rb_valid, busy and done.
  - Counters and word registers clear; state becomes IDLE.
  - pReset overrides start and every handshake.
- States:
  - IDLE: start → LOAD.
  - LOAD: after the last of CHAIN_LEN shifts → DONE.
  - DONE: start → LOAD, which clears done and all counters.
- start in LOAD is ignored.
- Words required: NW = ceil(CHAIN_LEN/WORD_W).
  - Final word contributes only CHAIN_LEN − (NW−1)·WORD_W bits; its upper bits are discarded.
  - Exactly NW words are accepted per load. in_ready is never high after the NW-th word.
- Word register: wreg, with a full flag.
  - in_ready = LOAD and words_accepted < NW and (not full, or this cycle shifts the last valid bit of wreg).
  - With in_valid held high, words stream with no bubble.
- Shift cycle: any LOAD cycle with wreg full.
  - chain_shift_en = 1 and ccff_head = wreg[0], both combinational from registered state.
  - On the edge: wreg shifts right and bit_cnt increments.
  - The same edge samples ccff_tail into the readback shift register.
  - On non-shift cycles ccff_head = 0 and chain_shift_en = 0.
- Throughput: one bit per cycle while words are supplied. An in_valid gap stalls shifting; no bit is lost or duplicated.
- Readback: tail bits are packed LSB-first into rb_data.
  - rb_valid pulses the cycle after the WORD_W-th bit, or after the final chain bit.
  - A partial final word is zero-padded in its upper bits.
  - There is no backpressure. rb_data holds until the next pulse.
- Completion:
  - The edge performing shift CHAIN_LEN enters DONE.
  - In the next cycle done = 1, busy = 0, and the final rb_valid pulses.
- Reset mid-LOAD: shifting stops immediately, the state returns to IDLE, and chain contents are undefined. A new start reloads the full chain.
- Simultaneous start and pReset: pReset wins.

Test Plan:
- Single load. Setup: CHAIN_LEN=20, WORD_W=8. Stimulus: start at cycle 0, then words 0xA5, 0x3C, 0x0F offered back-to-back. Required response:
  - in_ready is first high in cycle 1.
  - chain_shift_en is high for exactly 20 contiguous cycles, 2–21.
  - ccff_head sequence is 1,0,1,0,0,1,0,1, then 0,0,1,1,1,1,0,0, then 1,1,1,1.
  - done = 1 in cycle 22.
  - Exactly 3 words are accepted.
- Readback round-trip: model the chain as a 20-bit shifter preloaded with 0xFFFFF and load 0x00 ×3. Required: rb_data = 0xFF, 0xFF, 0x0F; the third word is zero-padded.
- Stalled source: in_valid low for 5 cycles between words 1 and 2. Required:
  - chain_shift_en is low for those cycles.
  - The ccff_head bit order is identical to the single-load scenario.
  - Total shifts = 20.
- Discarded bits: final word 0xFF. Required: only 4 ones are shifted, and in_ready stays 0 after the third acceptance.
- start during LOAD is ignored: the bit count is unchanged and done rises once. start in DONE begins a new load and clears done the next cycle.
- pReset asserted at shift 10. Required:
  - The next cycle has all outputs 0 and the state is IDLE.
  - A following start produces a full 20 shifts.
